serial_mag_comp: RTL and testbench

- Sequential, digit-serial counterpart to the team's flat combinational 16-bit magnitude comparator.
- Accepts an operand pair A/B over a valid/ready handshake and scans it MSB-first, one DIGIT-bit digit per cycle.
- Stops at the first differing digit and returns a one-hot GT/EQ/LT result over a second valid/ready handshake.
- Used where comparator area matters more than latency, e.g. shared compare resources in control paths.

---
 rtl/serial_mag_comp.sv | 107 ++++++++++
 tb/tb_serial_mag_comp.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comp.sv
// serial_mag_comp: digit-serial unsigned magnitude comparator. Scans A/B MSB-first,
// one DIGIT-bit digit per cycle, exits on the first differing digit.
module serial_mag_comp #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4,
    parameter int CNTW  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [CNTW-1:0]  scan_cnt
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
    logic [DIGIT-1:0] a_dig, b_dig;

    assign a_dig = a_q[DIGIT*idx_q +: DIGIT];
    assign b_dig = b_q[DIGIT*idx_q +: DIGIT];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = b;
                idx_d   = IW'(NDIG - 1);
                cnt_d   = '0;
                state_d = SCAN;
            end
            SCAN: begin
                cnt_d = cnt_q + CNTW'(1);
                // idx==0 always exits, so idx never wraps
                if (a_dig != b_dig || idx_q == '0) begin
                    gt_d    = a_dig > b_dig;
                    lt_d    = a_dig < b_dig;
                    eq_d    = a_dig == b_dig;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: if (out_ready) begin
                gt_d    = 1'b0;
                eq_d    = 1'b0;
                lt_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign gt        = gt_q;
    assign eq        = eq_q;
    assign lt        = lt_q;
    assign scan_cnt  = cnt_q;

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0({gt_q, eq_q, lt_q}));
    assert property (@(posedge clk) disable iff (!rst_n) out_valid |-> $onehot({gt_q, eq_q, lt_q}));
    assert property (@(posedge clk) disable iff (!rst_n) !(in_ready && out_valid));
endmodule

// File: tb/tb_serial_mag_comp.sv
// tb_serial_mag_comp: scoreboard bench; a negedge monitor pushes expected results on
// accept and pops/compares on each output transfer, scenario tasks add targeted checks.
module tb_serial_mag_comp;
    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int CNTW  = 3;
    localparam int NDIG  = WIDTH / DIGIT;

    typedef struct packed {
        logic [2:0] res;
        logic [2:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             in_ready, out_valid, gt, eq, lt;
    logic [CNTW-1:0]  scan_cnt;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_acc = 0;
    int   n_out = 0;
    logic prev_ov = 1'b0;
    exp_t sbq[$];
    exp_t me;

    logic [15:0] ta [5] = '{16'hA000, 16'h9FFF, 16'h1234, 16'hFFFF, 16'h0000};
    logic [15:0] tb [5] = '{16'h9FFF, 16'hA000, 16'h1235, 16'hFFFF, 16'h0000};
    logic [2:0]  tr [5] = '{3'b100, 3'b001, 3'b001, 3'b010, 3'b010};
    int          tc [5] = '{1, 1, 4, 4, 4};

    always #5 clk = ~clk;

    serial_mag_comp #(.WIDTH(WIDTH), .DIGIT(DIGIT), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .gt(gt), .eq(eq), .lt(lt), .scan_cnt(scan_cnt)
    );

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t e;
        e.res = (x > y) ? 3'b100 : (x < y) ? 3'b001 : 3'b010;
        e.cnt = 3'(NDIG);
        for (int k = NDIG - 1; k >= 0; k--)
            if (x[WIDTH-1-DIGIT*k -: DIGIT] != y[WIDTH-1-DIGIT*k -: DIGIT]) e.cnt = 3'(k + 1);
        return e;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            sbq.delete();
            prev_ov = 1'b0;
        end else begin
            checks++;
            if (in_ready && out_valid) begin
                failures++;
                $display("FAIL inv_ready_valid: in_ready=%b out_valid=%b, required not both 1", in_ready, out_valid);
            end
            checks++;
            if (out_valid ? !$onehot({gt, eq, lt}) : ({gt, eq, lt} !== 3'b000)) begin
                failures++;
                $display("FAIL inv_onehot: out_valid=%b gt/eq/lt=%b", out_valid, {gt, eq, lt});
            end
            if (out_valid && !prev_ov) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL sb_spurious: out_valid=1 with no pair in flight");
                end else if (cyc - acc_cyc != int'(sbq[0].cnt) + 1) begin
                    failures++;
                    $display("FAIL sb_latency: got %0d cycles, required %0d", cyc - acc_cyc - 1, sbq[0].cnt);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL sb_extra: output transfer with empty scoreboard");
                end else begin
                    me = sbq.pop_front();
                    n_out++;
                    if ({gt, eq, lt} !== me.res || scan_cnt !== me.cnt) begin
                        failures++;
                        $display("FAIL sb_result: got gt/eq/lt=%b cnt=%0d, required %b cnt=%0d",
                                 {gt, eq, lt}, scan_cnt, me.res, me.cnt);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sbq.push_back(model(a, b));
                acc_cyc = cyc;
                n_acc++;
            end
            prev_ov = out_valid;
        end
    end

    task automatic test_reset();
        int w;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, gt, eq, lt, scan_cnt} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_init: got rdy/vld/gel/cnt=%b, required 10000000", {in_ready, out_valid, gt, eq, lt, scan_cnt});
        end
        rst_n = 1'b1;
        @(posedge clk); #1 a = 16'h1234; b = 16'h1234; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1 in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin @(posedge clk); #1 w++; end
        checks++;
        if (!out_valid) begin failures++; $display("FAIL reset_done_timeout: out_valid=0, required 1"); end
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, gt, eq, lt, scan_cnt} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_mid_done: got rdy/vld/gel/cnt=%b, required 10000000", {in_ready, out_valid, gt, eq, lt, scan_cnt});
        end
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        w = 0;
        repeat (8) begin @(negedge clk); if (out_valid) w++; end
        checks++;
        if (w != 0) begin failures++; $display("FAIL reset_discard: out_valid seen %0d cycles, required 0", w); end
    endtask

    task automatic test_decisions();
        int lat;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 a = ta[i]; b = tb[i]; in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1 in_valid = 1'b0;
            @(negedge clk);
            lat = 0;
            while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
            checks++;
            if (lat != tc[i]) begin failures++; $display("FAIL dec_latency[%0d]: got %0d, required %0d", i, lat, tc[i]); end
            checks++;
            if ({gt, eq, lt} !== tr[i] || scan_cnt !== 3'(tc[i])) begin
                failures++;
                $display("FAIL dec_result[%0d]: got %b cnt=%0d, required %b cnt=%0d", i, {gt, eq, lt}, scan_cnt, tr[i], tc[i]);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL dec_one_cycle[%0d]: out_valid=%b, required 0", i, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        int w, bad, acc0;
        @(posedge clk); #1 a = 16'h0100; b = 16'h00FF; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1 a = 16'($urandom); b = 16'($urandom);
        w = 0;
        while (!out_valid && w < 20) begin @(posedge clk); #1 a = 16'($urandom); b = 16'($urandom); w++; end
        checks++;
        if (!out_valid) begin failures++; $display("FAIL bp_timeout: out_valid=0, required 1"); end
        acc0 = n_acc;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if ({out_valid, in_ready, gt, eq, lt, scan_cnt} !== {1'b1, 1'b0, 3'b100, 3'd2}) bad++;
            @(posedge clk); #1 a = 16'($urandom); b = 16'($urandom);
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL bp_hold: %0d unstable cycles, required 0", bad); end
        a = 16'h0003; b = 16'h0003; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || n_acc != acc0 + 1) begin
            failures++;
            $display("FAIL bp_next_accept: in_ready=%b accepts=%0d, required 0 %0d", in_ready, n_acc - acc0, 1);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        w = 0;
        while ((sbq.size() != 0 || out_valid) && w < 30) begin @(negedge clk); w++; end
        checks++;
        if (sbq.size() != 0) begin failures++; $display("FAIL bp_drain: %0d pending, required 0", sbq.size()); end
    endtask

    task automatic test_back_to_back();
        int g, w, acc0, out0;
        acc0 = n_acc;
        out0 = n_out;
        g = 0;
        @(posedge clk); #1 in_valid = 1'b1;
        while (n_acc - acc0 < 1000 && g < 30000) begin
            @(posedge clk); #1;
            a = 16'($urandom);
            case ($urandom_range(0, 2))
                0: b = 16'($urandom);
                1: b = a ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
                default: b = a;
            endcase
            out_ready = 1'($urandom_range(0, 1));
            g++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (n_acc - acc0 != 1000) begin failures++; $display("FAIL b2b_accepts: got %0d, required 1000", n_acc - acc0); end
        w = 0;
        while ((sbq.size() != 0 || out_valid) && w < 100) begin @(negedge clk); w++; end
        checks++;
        if (sbq.size() != 0) begin failures++; $display("FAIL b2b_drain: %0d pending, required 0", sbq.size()); end
        checks++;
        if (n_out - out0 != 1000) begin failures++; $display("FAIL b2b_outputs: got %0d, required 1000", n_out - out0); end
    endtask

    task automatic test_reset_mid_scan();
        int w;
        @(posedge clk); #1 a = 16'h5555; b = 16'h5555; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, gt, eq, lt, scan_cnt} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL rst_scan_values: got rdy/vld/gel/cnt=%b, required 10000000", {in_ready, out_valid, gt, eq, lt, scan_cnt});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        w = 0;
        repeat (8) begin @(negedge clk); if (out_valid) w++; end
        checks++;
        if (w != 0) begin failures++; $display("FAIL rst_scan_discard: out_valid seen %0d cycles, required 0", w); end
        @(posedge clk); #1 a = 16'h0001; b = 16'h0002; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin @(negedge clk); w++; end
        checks++;
        if ({out_valid, gt, eq, lt, scan_cnt} !== {1'b1, 3'b001, 3'd4}) begin
            failures++;
            $display("FAIL rst_scan_next: got vld=%b gel=%b cnt=%0d, required 1 001 4", out_valid, {gt, eq, lt}, scan_cnt);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_decisions();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
